// File: rtl/ei_regbank_if.sv
// ei_regbank_if: host and internal access ports of the register bank
interface ei_regbank_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 64,
    parameter int ADDR_WIDTH = $clog2(DATA_DEPTH)
);
    logic                  h_wr_en, h_rd_en, h_rvalid, h_err;
    logic [ADDR_WIDTH-1:0] h_addr;
    logic [DATA_WIDTH-1:0] h_wdata, h_rdata;
    logic                  i_wr_en, i_rd_en, i_rvalid;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_wdata, i_rdata;
    modport master (
        output h_wr_en, h_rd_en, h_addr, h_wdata, i_wr_en, i_rd_en, i_addr, i_wdata,
        input  h_rdata, h_rvalid, h_err, i_rdata, i_rvalid
    );
    modport slave (
        input  h_wr_en, h_rd_en, h_addr, h_wdata, i_wr_en, i_rd_en, i_addr, i_wdata,
        output h_rdata, h_rvalid, h_err, i_rdata, i_rvalid
    );
endinterface

// File: rtl/ei_regbank.sv
// ei_regbank: dual-port config register bank with host read-only mask, dirty tracking and restore
module ei_regbank #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 64,
    parameter int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    ei_regbank_if.slave                      bus,
    input  logic [DATA_DEPTH*DATA_WIDTH-1:0] def_regs,
    input  logic [DATA_DEPTH-1:0]            mode_mask,
    input  logic                             restore,
    output logic [DATA_DEPTH-1:0]            dirty,
    input  logic [DATA_DEPTH-1:0]            dirty_clr,
    output logic                             init_done
);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DATA_DEPTH);
    typedef enum logic {LOAD, RUN} state_t;
    state_t state, state_nxt;
    logic load, act, warm, h_in, i_in, i_wr_ok, collide, h_wr_ok, err_nxt;
    logic [DATA_DEPTH-1:0] h_set;
    logic [DATA_WIDTH-1:0] regs [DATA_DEPTH];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= LOAD;
        else state <= state_nxt;
    always_comb state_nxt = (state == RUN && restore) ? LOAD : RUN;
    always_comb begin
        load = state == LOAD;
        act  = state == RUN && init_done && !restore;
    end
    always_comb begin
        h_in    = {1'b0, bus.h_addr} < DEPTH_LIM;
        i_in    = {1'b0, bus.i_addr} < DEPTH_LIM;
        i_wr_ok = bus.i_wr_en && i_in;
        collide = i_wr_ok && bus.i_addr == bus.h_addr;
        h_wr_ok = bus.h_wr_en && h_in && !mode_mask[bus.h_addr] && !collide;
        h_set   = (act && h_wr_ok) ? DATA_DEPTH'(1) << bus.h_addr : '0;
        err_nxt = act && ((bus.h_wr_en && !h_wr_ok) || (bus.h_rd_en && !h_in));
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int k = 0; k < DATA_DEPTH; k++) regs[k] <= '0;
        else if (load) for (int k = 0; k < DATA_DEPTH; k++) regs[k] <= def_regs[k*DATA_WIDTH +: DATA_WIDTH];
        else if (act) begin
            if (h_wr_ok) regs[bus.h_addr] <= bus.h_wdata;
            if (i_wr_ok) regs[bus.i_addr] <= bus.i_wdata;
        end
    // a cold start waits one extra edge before init_done; a restore reload does not
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            warm      <= 1'b0;
            init_done <= 1'b0;
            dirty     <= '0;
        end else begin
            warm      <= warm || load;
            init_done <= load ? warm : (state == RUN && !restore);
            dirty     <= (state == RUN && restore) ? '0 : h_set | (dirty & ~dirty_clr);
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.h_rdata  <= '0;
            bus.h_rvalid <= 1'b0;
            bus.h_err    <= 1'b0;
            bus.i_rdata  <= '0;
            bus.i_rvalid <= 1'b0;
        end else begin
            bus.h_rvalid <= act && bus.h_rd_en;
            bus.i_rvalid <= act && bus.i_rd_en;
            bus.h_err    <= err_nxt;
            if (act && bus.h_rd_en) bus.h_rdata <= h_in ? regs[bus.h_addr] : '0;
            if (act && bus.i_rd_en) bus.i_rdata <= i_in ? regs[bus.i_addr] : '0;
        end
endmodule

// File: tb/tb_ei_regbank.sv
// tb_ei_regbank: scoreboard bench for ei_regbank at depth 64 and a non-power-of-two depth 40
module tb_ei_regbank;
    typedef struct packed {logic rv; logic [7:0] d; logic err;} resp_t;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    ei_regbank_if #(.DATA_WIDTH(8), .DATA_DEPTH(64)) bus ();
    ei_regbank_if #(.DATA_WIDTH(8), .DATA_DEPTH(40)) sbus ();
    logic [511:0] def_regs;
    logic [63:0]  mode_mask, dirty, dirty_clr;
    logic         restore, init_done;
    logic [319:0] s_def;
    logic [39:0]  s_mask, s_dirty, s_clr;
    logic         s_restore, s_init;
    resp_t hq[$], iq[$], sq[$];
    int errors = 0, checks = 0;
    ei_regbank #(.DATA_WIDTH(8), .DATA_DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .def_regs(def_regs), .mode_mask(mode_mask),
        .restore(restore), .dirty(dirty), .dirty_clr(dirty_clr), .init_done(init_done));
    ei_regbank #(.DATA_WIDTH(8), .DATA_DEPTH(40)) sdut (
        .clk(clk), .rst_n(rst_n), .bus(sbus), .def_regs(s_def), .mode_mask(s_mask),
        .restore(s_restore), .dirty(s_dirty), .dirty_clr(s_clr), .init_done(s_init));
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (bus.h_rvalid || bus.h_err) begin
            if (hq.size() == 0) chk("host unexpected", {bus.h_rvalid, bus.h_rdata, bus.h_err}, 0);
            else chk("host resp", {bus.h_rvalid, bus.h_rvalid ? bus.h_rdata : 8'h00, bus.h_err}, hq.pop_front());
        end
        if (bus.i_rvalid) begin
            if (iq.size() == 0) chk("int unexpected", {1'b1, bus.i_rdata, 1'b0}, 0);
            else chk("int resp", {1'b1, bus.i_rdata, 1'b0}, iq.pop_front());
        end
        if (sbus.h_rvalid || sbus.h_err) begin
            if (sq.size() == 0) chk("small unexpected", {sbus.h_rvalid, sbus.h_rdata, sbus.h_err}, 0);
            else chk("small resp", {sbus.h_rvalid, sbus.h_rvalid ? sbus.h_rdata : 8'h00, sbus.h_err}, sq.pop_front());
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
        {bus.h_wr_en, bus.h_rd_en, bus.i_wr_en, bus.i_rd_en} = '0;
        {sbus.h_wr_en, sbus.h_rd_en, sbus.i_wr_en, sbus.i_rd_en} = '0;
        {restore, s_restore} = '0;
        dirty_clr = '0;
        s_clr = '0;
    endtask
    task automatic host(input logic wr, rd, input logic [5:0] a, input logic [7:0] wd,
                        input logic [7:0] exp_d, input logic exp_err);
        bus.h_wr_en = wr; bus.h_rd_en = rd; bus.h_addr = a; bus.h_wdata = wd;
        if (rd || exp_err) hq.push_back({rd, rd ? exp_d : 8'h00, exp_err});
    endtask
    task automatic intl(input logic wr, rd, input logic [5:0] a, input logic [7:0] wd, input logic [7:0] exp_d);
        bus.i_wr_en = wr; bus.i_rd_en = rd; bus.i_addr = a; bus.i_wdata = wd;
        if (rd) iq.push_back({1'b1, exp_d, 1'b0});
    endtask
    task automatic shost(input logic wr, rd, input logic [5:0] a, input logic [7:0] exp_d, input logic exp_err);
        sbus.h_wr_en = wr; sbus.h_rd_en = rd; sbus.h_addr = a; sbus.h_wdata = 8'hC3;
        if (rd || exp_err) sq.push_back({rd, rd ? exp_d : 8'h00, exp_err});
    endtask
    initial begin
        {bus.h_wr_en, bus.h_rd_en, bus.i_wr_en, bus.i_rd_en} = '0;
        {sbus.h_wr_en, sbus.h_rd_en, sbus.i_wr_en, sbus.i_rd_en} = '0;
        {bus.h_addr, bus.h_wdata, bus.i_addr, bus.i_wdata} = '0;
        {sbus.h_addr, sbus.h_wdata, sbus.i_addr, sbus.i_wdata} = '0;
        {restore, s_restore} = '0;
        dirty_clr = '0; s_clr = '0; s_mask = '0;
        mode_mask = 64'h20;
        for (int k = 0; k < 64; k++) def_regs[k*8 +: 8] = 8'(k + 16);
        for (int k = 0; k < 40; k++) s_def[k*8 +: 8] = 8'(k + 16);
        repeat (2) @(posedge clk);
        #1;
        chk("reset init_done", init_done, 0);
        chk("reset dirty", dirty, 0);
        chk("reset outputs", {bus.h_rvalid, bus.h_rdata, bus.h_err, bus.i_rvalid, bus.i_rdata}, 0);
        rst_n = 1'b1;
        bus.h_rd_en = 1'b1; bus.h_wr_en = 1'b1; bus.h_wdata = 8'hEE;
        @(posedge clk);
        #1;
        chk("init_done edge1", init_done, 0);
        @(posedge clk);
        #1;
        chk("init_done edge2", init_done, 1);
        chk("startup dirty", dirty, 0);
        bus.h_rd_en = 1'b0; bus.h_wr_en = 1'b0;
        for (int k = 0; k < 64; k++) begin
            host(0, 1, 6'(k), 0, 8'(k + 16), 0);
            tick();
        end
        intl(0, 1, 2, 0, 8'h12);
        tick();
        host(1, 0, 5, 8'hAA, 0, 1);
        tick();
        chk("ro dirty5", dirty[5], 0);
        host(0, 1, 5, 0, 8'h15, 0);
        intl(1, 0, 5, 8'h55, 0);
        tick();
        host(0, 1, 5, 0, 8'h55, 0);
        tick();
        host(1, 1, 10, 8'h66, 8'h1A, 0);
        tick();
        host(0, 1, 10, 0, 8'h66, 0);
        intl(0, 1, 10, 0, 8'h66);
        tick();
        chk("dirty10", dirty[10], 1);
        host(1, 0, 7, 8'h12, 0, 1);
        intl(1, 0, 7, 8'h34, 0);
        tick();
        chk("collide dirty7", dirty[7], 0);
        host(0, 1, 7, 0, 8'h34, 0);
        tick();
        host(1, 0, 8, 8'h12, 0, 0);
        intl(1, 0, 9, 8'h34, 0);
        tick();
        host(0, 1, 8, 0, 8'h12, 0);
        intl(0, 1, 9, 0, 8'h34);
        tick();
        chk("dirty8", dirty[8], 1);
        chk("dirty9", dirty[9], 0);
        host(1, 0, 3, 8'h77, 0, 0);
        dirty_clr[3] = 1'b1;
        tick();
        chk("set beats clr", dirty[3], 1);
        dirty_clr[3] = 1'b1;
        tick();
        chk("clr alone", dirty[3], 0);
        chk("dirty8 kept", dirty[8], 1);
        shost(0, 1, 45, 8'h00, 1);
        sbus.i_wr_en = 1'b1; sbus.i_addr = 45; sbus.i_wdata = 8'h99;
        tick();
        shost(1, 0, 40, 0, 1);
        tick();
        shost(0, 1, 13, 8'h1D, 0);
        tick();
        shost(0, 1, 39, 8'h37, 0);
        tick();
        chk("small dirty", s_dirty, 0);
        for (int k = 0; k < 64; k++) begin
            intl(1, 0, 6'(k), 8'hFF, 0);
            tick();
        end
        host(0, 1, 0, 0, 8'hFF, 0);
        tick();
        host(1, 1, 0, 8'h00, 0, 0);
        hq.pop_back();
        restore = 1'b1;
        tick();
        chk("restore dirty", dirty, 0);
        chk("restore init low", init_done, 0);
        tick();
        chk("restore init back", init_done, 1);
        for (int k = 0; k < 64; k++) begin
            host(0, 1, 6'(k), 0, 8'(k + 16), 0);
            tick();
        end
        host(1, 0, 20, 8'h5A, 0, 0);
        tick();
        chk("dirty20", dirty, 64'h10_0000);
        bus.h_rd_en = 1'b1; bus.h_addr = 20;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", {bus.h_rvalid, bus.h_rdata, bus.h_err, init_done}, 0);
        chk("async reset dirty", dirty, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("host queue drained", hq.size(), 0);
        chk("int queue drained", iq.size(), 0);
        chk("small queue drained", sq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
